// File: rtl/dds_phase_core.sv
// dds_phase_core: clamped step load, 32-bit phase accumulator and a
// 3-stage quarter-wave sine pipeline (fold -> ROM read -> unfold).
module dds_phase_core #(
  parameter int          PHASE_W  = 32,
  parameter int          LUT_AW   = 10,
  parameter int          OUT_W    = 10,
  parameter logic [31:0] STEP_MIN = 32'd858993,
  parameter logic [31:0] STEP_MAX = 32'd171798691
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] Step,
  input  logic               step_valid,
  output logic               step_ack,
  output logic               step_clamped,
  input  logic               enable,
  input  logic               phase_clr,
  output logic [PHASE_W-1:0] phase_out,
  output logic [OUT_W-1:0]   sine_out,
  output logic               out_valid,
  output logic               sync_out
);

  localparam int               STAGES = 3;
  localparam int               ROM_N  = 2 ** LUT_AW;
  localparam logic [OUT_W-1:0] HALF   = OUT_W'(2 ** (OUT_W - 1));
  localparam logic [OUT_W-1:0] HIGH   = OUT_W'(2 ** (OUT_W - 1) - 1);
  localparam logic [63:0]      PI_Q60 = 64'h3243F6A8885A308D;

  // ROM entry i = round(AMP * sin(pi/2 * (i+0.5) / 2^LUT_AW)), evaluated at
  // elaboration in Q60 fixed point (Taylor series, 12 terms is ample for x < pi/2).
  function automatic logic [OUT_W-2:0] quarter_sine(input int idx);
    logic [127:0] x, x2, term, sum;
    x    = (128'(PI_Q60) * 128'(2 * idx + 1)) >> (LUT_AW + 2);
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) sum = sum - term;
      else              sum = sum + term;
    end
    return (OUT_W-1)'((sum * 128'(2 ** (OUT_W - 1) - 1) + (128'd1 << 59)) >> 60);
  endfunction

  logic [OUT_W-2:0] rom [ROM_N];

  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    localparam logic [OUT_W-2:0] MVAL = quarter_sine(gi);
    assign rom[gi] = MVAL;
  end

  logic [PHASE_W-1:0] acc, step_act;
  logic [PHASE_W:0]   acc_sum;
  logic               mark;
  logic               step_lo, step_hi;
  logic [LUT_AW+1:0]  p;
  logic [1:0]         q1, q2;
  logic [LUT_AW-1:0]  a1;
  logic               mark1, mark2;
  logic [OUT_W-2:0]   m2;
  logic [STAGES-1:0]  vld_pipe;

  assign step_lo   = Step < STEP_MIN;
  assign step_hi   = Step > STEP_MAX;
  assign acc_sum   = {1'b0, acc} + {1'b0, step_act};
  assign p         = acc[PHASE_W-1 -: LUT_AW+2];
  assign phase_out = acc;
  assign out_valid = vld_pipe[STAGES-1];

  // Step register: clamp into the legal band, flag clamping, ack next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_act     <= STEP_MAX;
      step_ack     <= 1'b0;
      step_clamped <= 1'b0;
    end else begin
      step_ack <= step_valid;
      if (step_valid) begin
        step_clamped <= step_lo | step_hi;
        step_act     <= step_lo ? STEP_MIN : (step_hi ? STEP_MAX : Step);
      end
    end
  end

  // Accumulator; mark flags a wrap or a clear so sync can ride with the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      mark <= 1'b0;
    end else if (phase_clr) begin
      acc  <= '0;
      mark <= 1'b1;
    end else if (enable) begin
      {mark, acc} <= acc_sum;
    end else begin
      mark <= 1'b0;
    end
  end

  // Pipeline valid shift register; fills once after reset and then stays full.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
  end

  // S1: split quadrant and fold the address into the first quarter.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1    <= '0;
      a1    <= '0;
      mark1 <= 1'b0;
    end else begin
      q1    <= p[LUT_AW+1:LUT_AW];
      a1    <= p[LUT_AW] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
      mark1 <= mark;
    end
  end

  // S2: synchronous ROM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      q2    <= '0;
      m2    <= '0;
      mark2 <= 1'b0;
    end else begin
      q2    <= q1;
      m2    <= rom[a1];
      mark2 <= mark1;
    end
  end

  // S3: unfold the sign into offset binary; hold mid-scale until data is real.
  always_ff @(posedge clk) begin
    if (reset) begin
      sine_out <= HALF;
      sync_out <= 1'b0;
    end else if (vld_pipe[STAGES-2]) begin
      sine_out <= q2[1] ? (HIGH - {1'b0, m2}) : (HALF + {1'b0, m2});
      sync_out <= mark2;
    end else begin
      sine_out <= HALF;
      sync_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_phase_core.sv
// tb_dds_phase_core: directed vectors plus a random run; a cycle model pushes
// expected samples into a queue, a negedge monitor pops and compares them.
module tb_dds_phase_core;

  localparam logic [31:0] SMIN = 32'd858993;
  localparam logic [31:0] SMAX = 32'd171798691;
  localparam real         PI   = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Step = '0;
  logic        step_valid = 1'b0;
  logic        enable = 1'b0;
  logic        phase_clr = 1'b0;
  logic        step_ack, step_clamped, out_valid, sync_out;
  logic [31:0] phase_out;
  logic [9:0]  sine_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dds_phase_core dut (
    .clk         (clk),
    .reset       (reset),
    .Step        (Step),
    .step_valid  (step_valid),
    .step_ack    (step_ack),
    .step_clamped(step_clamped),
    .enable      (enable),
    .phase_clr   (phase_clr),
    .phase_out   (phase_out),
    .sine_out    (sine_out),
    .out_valid   (out_valid),
    .sync_out    (sync_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry {quadrant, sync, sample} for an accumulator value.
  function automatic logic [12:0] exp_entry(input logic [31:0] a_val, input logic mk);
    logic [1:0] q;
    logic [9:0] a;
    logic [9:0] s;
    int         m;
    q = a_val[31:30];
    a = a_val[29:20];
    if (q[0]) a = ~a;
    m = $rtoi(511.0 * $sin(PI / 2.0 * (real'(a) + 0.5) / 1024.0) + 0.5);
    s = q[1] ? 10'(511 - m) : 10'(512 + m);
    return {q, mk, s};
  endfunction

  // Reference model state.
  logic [31:0] m_acc = '0;
  logic [31:0] m_step = SMAX;
  logic [32:0] m_sum;
  logic        m_ack = 1'b0, m_clamped = 1'b0, m_mark = 1'b0;
  logic        started = 1'b0;
  int          m_vld = 0;
  logic [12:0] sb[$];
  logic [12:0] e;
  int          qcnt [4] = '{default: 0};

  // Model: advance on each edge from the inputs and queue the new sample.
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_acc = '0; m_step = SMAX; m_ack = 1'b0; m_clamped = 1'b0;
      m_mark = 1'b0; m_vld = 0;
      sb.delete();
    end else begin
      if (phase_clr) begin
        m_acc = '0; m_mark = 1'b1;
      end else if (enable) begin
        m_sum = {1'b0, m_acc} + {1'b0, m_step};
        m_acc = m_sum[31:0]; m_mark = m_sum[32];
      end else begin
        m_mark = 1'b0;
      end
      m_ack = step_valid;
      if (step_valid) begin
        if (Step < SMIN)      begin m_step = SMIN; m_clamped = 1'b1; end
        else if (Step > SMAX) begin m_step = SMAX; m_clamped = 1'b1; end
        else                  begin m_step = Step; m_clamped = 1'b0; end
      end
      if (m_vld < 3) m_vld++;
    end
    sb.push_back(exp_entry(m_acc, m_mark));
  end

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("phase_out", phase_out, m_acc);
      chk("step_ack", step_ack, m_ack);
      chk("step_clamped", step_clamped, m_clamped);
      chk("out_valid", out_valid, m_vld >= 3);
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: out_valid high with nothing expected at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sine_out", sine_out, e[9:0]);
          chk("sync_out", sync_out, e[10]);
          qcnt[e[12:11]]++;
        end
      end else begin
        chk("sine_idle", sine_out, 512);
        chk("sync_idle", sync_out, 0);
      end
    end
  end

  initial begin
    // Default run after reset.
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_valid_e2", out_valid, 0);
    chk("a_sine_e2", sine_out, 512);
    @(negedge clk);
    chk("a_valid_e3", out_valid, 1);
    @(negedge clk);
    chk("a_phase_e4", phase_out, 687194764);
    chk("a_sine_e4", sine_out, 639);

    // In-range load together with a clear.
    phase_clr = 1'b1; step_valid = 1'b1; Step = SMIN;
    @(negedge clk);
    chk("b_phase0", phase_out, 0);
    chk("b_ack", step_ack, 1);
    chk("b_clamped", step_clamped, 0);
    phase_clr = 1'b0; step_valid = 1'b0;
    @(negedge clk);
    chk("b_phase1", phase_out, 858993);
    chk("b_ack_off", step_ack, 0);
    @(negedge clk);
    chk("b_phase2", phase_out, 1717986);

    // Clamping low, high, then a legal step held for three cycles.
    phase_clr = 1'b1; step_valid = 1'b1; Step = 32'd5;
    @(negedge clk);
    chk("c_lo_clamped", step_clamped, 1);
    phase_clr = 1'b0; step_valid = 1'b0;
    @(negedge clk);
    chk("c_lo_phase", phase_out, 858993);
    phase_clr = 1'b1; step_valid = 1'b1; Step = 32'hFFFFFFFF;
    @(negedge clk);
    chk("c_hi_clamped", step_clamped, 1);
    phase_clr = 1'b0; step_valid = 1'b0;
    @(negedge clk);
    chk("c_hi_phase", phase_out, 171798691);
    phase_clr = 1'b1; step_valid = 1'b1; Step = 32'd1000000;
    @(negedge clk);
    chk("c_mid_clamped", step_clamped, 0);
    chk("c_ack0", step_ack, 1);
    phase_clr = 1'b0;
    @(negedge clk);
    chk("c_ack1", step_ack, 1);
    chk("c_mid_phase1", phase_out, 1000000);
    @(negedge clk);
    chk("c_ack2", step_ack, 1);
    chk("c_mid_phase2", phase_out, 2000000);
    step_valid = 1'b0;
    @(negedge clk);
    chk("c_ack_off", step_ack, 0);
    chk("c_mid_phase3", phase_out, 3000000);

    // Sync on clear and on wrap; flush earlier marks first.
    enable = 1'b0;
    repeat (4) @(negedge clk);
    phase_clr = 1'b1; step_valid = 1'b1; Step = SMAX; enable = 1'b1;
    @(negedge clk);
    chk("d_phase0", phase_out, 0);
    phase_clr = 1'b0; step_valid = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      chk($sformatf("d_sync_n%0d", n), sync_out, (n == 3) || (n == 29));
      if (n == 1)  chk("d_phase1", phase_out, 171798691);
      if (n == 25) chk("d_phase25", phase_out, 32'd4294967275);
      if (n == 26) chk("d_phase26", phase_out, 171798670);
    end

    // Hold: phase frozen, sample settles three cycles after enable falls.
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("e_phase_run", phase_out, 858993455);
    enable = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("e_hold_phase%0d", k), phase_out, 858993455);
      chk($sformatf("e_hold_valid%0d", k), out_valid, 1);
      if (k >= 3) chk($sformatf("e_hold_sine%0d", k), sine_out, 998);
    end

    // Random legal traffic; the monitor does the checking.
    for (int i = 0; i < 10000; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      step_valid = ($urandom_range(0, 15) == 0);
      Step       = $urandom_range(SMAX, SMIN);
      phase_clr  = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    step_valid = 1'b0; phase_clr = 1'b0;

    // Reset in mid-stream.
    Step = 32'd5; step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    chk("g_pre_clamped", step_clamped, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("g_phase", phase_out, 0);
    chk("g_ack", step_ack, 0);
    chk("g_clamped", step_clamped, 0);
    chk("g_sine", sine_out, 512);
    chk("g_valid", out_valid, 0);
    chk("g_sync", sync_out, 0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("g_step_default", phase_out, 171798691);
    repeat (4) @(negedge clk);

    for (int q = 0; q < 4; q++) chk($sformatf("quad%0d_seen", q), qcnt[q] > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
